// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, default baud divider and counter widths.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    PARITY = 3'd4
  } tx_state_e;

  localparam int DEF_BAUD_DIV = 5200;
  localparam int DATA_BITS    = 8;
  localparam int BIT_CNT_W    = 3;
  localparam int DIV_W        = 16;

endpackage

// File: rtl/uart_byte_tx_if.sv
// Byte-in / serial-out bundle between a byte source (master) and the UART transmitter (slave).
interface uart_byte_tx_if;
  import uart_pkg::*;

  // Send_En is a one-cycle strobe; it is taken only while Tx_Busy is low, and
  // Data_Byte is sampled in that same cycle. Tx_Done pulses once per finished frame.
  logic       Send_En;
  logic [7:0] Data_Byte;
  logic       Rs232_Tx;
  logic       Tx_Busy;
  logic       Tx_Done;
  tx_state_e  dbg_state;

  modport master (
    output Send_En, Data_Byte,
    input  Rs232_Tx, Tx_Busy, Tx_Done, dbg_state
  );

  modport slave (
    input  Send_En, Data_Byte,
    output Rs232_Tx, Tx_Busy, Tx_Done, dbg_state
  );
endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period divider: counts 0..BAUD_DIV-1 while enabled and flags the last count as a tick.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = DEF_BAUD_DIV
) (
  input  logic CLK,
  input  logic RST,
  input  logic en,
  output logic tick
);

  localparam logic [DIV_W-1:0] LAST = DIV_W'(BAUD_DIV - 1);

  logic [DIV_W-1:0] cnt_q;

  always_ff @(posedge CLK) begin
    if (RST || !en)         cnt_q <= '0;
    else if (cnt_q == LAST) cnt_q <= '0;
    else                    cnt_q <= cnt_q + DIV_W'(1);
  end

  assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/uart_byte_tx.sv
// 8-bit UART transmitter, LSB first, one stop bit. Define UART_TX_PARITY_EN to insert a
// parity bit (even by default, odd with PARITY_ODD=1) between D7 and the stop bit.
module uart_byte_tx
  import uart_pkg::*;
#(
  parameter int   BAUD_DIV = DEF_BAUD_DIV,
  parameter logic IDLE_LVL = 1'b1
`ifdef UART_TX_PARITY_EN
  ,
  parameter logic PARITY_ODD = 1'b0
`endif
) (
  input logic            CLK,
  input logic            RST,
  uart_byte_tx_if.slave  bus
);

  tx_state_e              state_q, state_nxt;
  logic [DATA_BITS-1:0]   shift_q, shift_nxt;
  logic [BIT_CNT_W-1:0]   bit_q, bit_nxt;
  logic                   line_q, line_nxt;
  logic                   busy_q;
  logic                   done_q, done_nxt;
  logic                   tick;
`ifdef UART_TX_PARITY_EN
  logic                   par_q, par_nxt;
`endif

  uart_baud_tick #(.BAUD_DIV(BAUD_DIV)) u_tick (
    .CLK  (CLK),
    .RST  (RST),
    .en   (state_q != IDLE),
    .tick (tick)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      line_q  <= IDLE_LVL;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_nxt;
      shift_q <= shift_nxt;
      bit_q   <= bit_nxt;
      line_q  <= line_nxt;
      busy_q  <= (state_nxt != IDLE);
      done_q  <= done_nxt;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state_q;
    shift_nxt = shift_q;
    bit_nxt   = bit_q;
    done_nxt  = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_nxt   = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.Send_En) begin
          state_nxt = START;
          shift_nxt = bus.Data_Byte;
`ifdef UART_TX_PARITY_EN
          par_nxt   = (^bus.Data_Byte) ^ PARITY_ODD;
`endif
        end
      end
      START: begin
        if (tick) begin
          state_nxt = DATA;
          bit_nxt   = '0;
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_q == BIT_CNT_W'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end else begin
            bit_nxt   = bit_q + BIT_CNT_W'(1);
            shift_nxt = {1'b0, shift_q[DATA_BITS-1:1]};
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (tick) state_nxt = STOP;
      end
`endif
      STOP: begin
        if (tick) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // The line is registered, so it is decoded from where the FSM is going next.
    case (state_nxt)
      START:   line_nxt = 1'b0;
      DATA:    line_nxt = shift_nxt[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  line_nxt = par_nxt;
`endif
      default: line_nxt = IDLE_LVL;
    endcase
  end

  assign bus.Rs232_Tx  = line_q;
  assign bus.Tx_Busy   = busy_q;
  assign bus.Tx_Done   = done_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_uart_byte_tx.sv
// Bench for uart_byte_tx at BAUD_DIV=4: frame-level model checked every cycle, a line decoder
// with an expected-byte queue, directed scenarios with literal expectations, then random traffic.
module tb_uart_byte_tx;
  import uart_pkg::*;

  localparam int B = 4;
`ifdef UART_TX_PARITY_EN
  localparam int  NBITS      = 11;
  localparam logic PARITY_ODD = 1'b0;
`else
  localparam int  NBITS      = 10;
`endif
  localparam int FB = NBITS * B;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;

  uart_byte_tx_if bus();

  uart_byte_tx #(
    .BAUD_DIV (B),
    .IDLE_LVL (1'b1)
`ifdef UART_TX_PARITY_EN
    ,
    .PARITY_ODD (PARITY_ODD)
`endif
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  // ---------------- model + scoreboard ----------------
  logic [7:0] exp_q[$];

  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx >= 1 && idx <= 8) return b[idx-1];
`ifdef UART_TX_PARITY_EN
    if (idx == 9) return (^b) ^ PARITY_ODD;
`endif
    return 1'b1;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d cyc=%0d", name, act, exp, cyc);
    end
  endtask

  logic       checking = 1'b0;
  logic       m_act = 1'b0;
  int         m_n = 0;
  logic [7:0] m_byte = '0;
  logic       dec_on = 1'b0;
  int         dec_k = 0;
  logic [7:0] dec_byte = '0;

  initial begin
    logic exp_line, exp_busy, exp_done;
    logic [7:0] want;
    int d;
    forever begin
      @(negedge CLK);
      exp_line = 1'b1; exp_busy = 1'b0; exp_done = 1'b0;
      if (checking) begin
        if (m_act) begin
          d = cyc - m_n;
          if (d >= 1 && d <= FB) begin
            exp_line = frame_bit(m_byte, (d - 1) / B);
            exp_busy = 1'b1;
          end else if (d == FB + 1) begin
            exp_done = 1'b1;
          end
        end
        chk("line", int'(bus.Rs232_Tx), int'(exp_line));
        chk("busy", int'(bus.Tx_Busy), int'(exp_busy));
        chk("done", int'(bus.Tx_Done), int'(exp_done));
        if (!exp_busy) chk("idle_state", int'(bus.dbg_state), int'(IDLE));
        if (bus.Tx_Done) done_cnt++;

        // line decoder: samples the middle of each bit period
        if (dec_on) begin
          if (bus.Tx_Done) begin
            dec_on = 1'b0;
            if (exp_q.size() == 0) begin
              chk("decode_unexpected", int'(dec_byte), -1);
            end else begin
              want = exp_q.pop_front();
              chk("decode_byte", int'(dec_byte), int'(want));
            end
          end else if (!bus.Tx_Busy) begin
            dec_on = 1'b0;
          end else begin
            dec_k++;
            if ((dec_k % B) == (B / 2) && (dec_k / B) >= 1 && (dec_k / B) <= 8)
              dec_byte[(dec_k / B) - 1] = bus.Rs232_Tx;
          end
        end else if (bus.Tx_Busy && !bus.Tx_Done && !bus.Rs232_Tx) begin
          dec_on = 1'b1;
          dec_k  = 0;
        end
      end

      // advance the model with the inputs the DUT samples at the coming edge
      if (RST) begin
        m_act = 1'b0;
        exp_q.delete();
        dec_on = 1'b0;
        checking = 1'b1;
      end else if (checking && bus.Send_En && !exp_busy) begin
        m_act  = 1'b1;
        m_n    = cyc;
        m_byte = bus.Data_Byte;
        exp_q.push_back(bus.Data_Byte);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) tick();
  endtask

  task automatic send(input logic [7:0] b, output int n);
    bus.Send_En   = 1'b1;
    bus.Data_Byte = b;
    n = cyc;
    tick();
    bus.Send_En   = 1'b0;
    bus.Data_Byte = 8'($urandom);
  endtask

  task automatic wait_done(input int lim);
    int k = 0;
    while (!bus.Tx_Done && k < lim) begin
      tick();
      k++;
    end
    if (!bus.Tx_Done) chk("done_timeout", 0, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int dc;
    bus.Send_En   = 1'b0;
    bus.Data_Byte = 8'h00;
    RST = 1'b1;
    repeat (3) tick();
    RST = 1'b0;
    repeat (100) tick();
    chk("idle_line", int'(bus.Rs232_Tx), 1);
    chk("idle_busy", int'(bus.Tx_Busy), 0);
    chk("idle_no_done", done_cnt, 0);

    // A5: literal timing
    send(8'hA5, n);
    chk("a5_start", int'(bus.Rs232_Tx), 0);
    chk("a5_busy", int'(bus.Tx_Busy), 1);
    wait_to(n + 5);  chk("a5_d0", int'(bus.Rs232_Tx), 1);
    wait_to(n + 9);  chk("a5_d1", int'(bus.Rs232_Tx), 0);
    wait_to(n + 33); chk("a5_d7", int'(bus.Rs232_Tx), 1);
    wait_to(n + FB); chk("a5_done_early", int'(bus.Tx_Done), 0);
    wait_to(n + FB + 1);
    chk("a5_done", int'(bus.Tx_Done), 1);
    chk("a5_busy_end", int'(bus.Tx_Busy), 0);
    tick();
    chk("a5_done_once", int'(bus.Tx_Done), 0);

    // 3C with an ignored FF strobe mid-frame
    dc = done_cnt;
    send(8'h3C, n);
    repeat (15) tick();
    bus.Send_En = 1'b1; bus.Data_Byte = 8'hFF;
    tick();
    bus.Send_En = 1'b0;
    wait_done(100);
    tick();
    chk("3c_one_done", done_cnt - dc, 1);
    repeat (20) tick();
    chk("3c_no_requeue", done_cnt - dc, 1);

    // 00 then 55 accepted in the Tx_Done cycle
    send(8'h00, n);
    wait_done(100);
    bus.Send_En = 1'b1; bus.Data_Byte = 8'h55;
    tick();
    bus.Send_En = 1'b0;
    chk("b2b_start", int'(bus.Rs232_Tx), 0);
    chk("b2b_busy", int'(bus.Tx_Busy), 1);
    wait_done(100);
    tick();

    // C3 reset during D3, then 81
    send(8'hC3, n);
    wait_to(n + 18);
    chk("c3_d3", int'(bus.Rs232_Tx), 0);
    dc = done_cnt;
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("rst_line", int'(bus.Rs232_Tx), 1);
    chk("rst_busy", int'(bus.Tx_Busy), 0);
    repeat (60) tick();
    chk("rst_no_done", done_cnt - dc, 0);
    send(8'h81, n);
    wait_done(100);
    chk("81_done_at", cyc - n, FB + 1);
    tick();

`ifdef UART_TX_PARITY_EN
    send(8'h07, n);
    wait_to(n + 37);
    chk("par_bit", int'(bus.Rs232_Tx), 1);
    wait_to(n + 45);
    chk("par_done", int'(bus.Tx_Done), 1);
    tick();
`endif

    // random traffic, rare resets
    for (int i = 0; i < 3000; i++) begin
      RST           = ($urandom_range(0, 399) == 0);
      bus.Send_En   = ($urandom_range(0, 15) == 0);
      bus.Data_Byte = 8'($urandom);
      tick();
    end
    RST = 1'b0;
    bus.Send_En = 1'b0;
    repeat (FB + 10) tick();
    chk("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
